xmas_twinkle: RTL and testbench
===============================

XMAS_TWINKLE -- requirements
Module: xmas_twinkle

Interface
REQ-001 Parameter: BLINK_FRAMES, default 30, frames per blink phase (legal 1..255).
REQ-002 clk  input  1  pixel clock, all state on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 enable  input  1  1 = twinkle overlay active, 0 = pass-through.
REQ-005 hsync_in  input  1  active-low horizontal sync from tree renderer.
REQ-006 vsync_in  input  1  active-low vertical sync from tree renderer.
REQ-007 red_in, green_in, blue_in  input  1 each  pixel colour from tree renderer.
REQ-008 hsync, vsync  output  1 each  syncs delayed to match pixel latency.
REQ-009 red, green, blue  output  1 each  registered output pixel colour.
REQ-010 lit  output  1  1 while FSM is in LIT state.

Function
REQ-011 Latency SHALL be exactly 1 clk from any input (hsync_in, vsync_in, rgb_in) to the corresponding output; syncs and colour remain aligned.
REQ-012 Edge detect: registered copies hs_d, vs_d; hs_rise = hsync_in & !hs_d; vs_rise = vsync_in & !vs_d.
REQ-013 x counter (11 bit) SHALL clear to 0 on the cycle hs_rise is seen, else increment, saturating at 2047.
REQ-014 y counter (10 bit) SHALL increment on hs_rise, saturating at 1023; vs_rise SHALL clear y to 0, taking priority over hs_rise.
REQ-015 Frame counter (8 bit) SHALL increment on each vs_rise; on reaching BLINK_FRAMES-1 with vs_rise, it SHALL clear to 0 and the FSM SHALL toggle.
REQ-016 FSM states DARK, LIT; DARK->LIT and LIT->DARK only on the toggle event of REQ-015.
REQ-017 enable=0 SHALL force FSM to DARK and hold frame counter at 0 on the next clk; x/y tracking continues.
REQ-018 LFSR: 8 bit, Fibonacci, taps 8,6,5,4 (x^8+x^6+x^5+x^4+1), shifts once exactly on each DARK->LIT transition; never 0.
REQ-019 Ornament pixel: x[3:0] in 6..9 AND y[3:0] in 6..9 AND input colour exactly r=0,g=1,b=0.
REQ-020 Ornament colour c = lfsr[2:0] XOR {x[6:4]} XOR {y[6:4]} as {r,g,b}; if c is 000 or 010, c SHALL be replaced by 111.
REQ-021 Output colour: if FSM=LIT and ornament pixel, c; otherwise rgb_in unchanged.
REQ-022 Non-green pixels (sky, trunk, blanking) SHALL never be modified.
REQ-023 Pixel decision uses x/y values before this cycle's update (registered counters).

Reset
REQ-024 During reset: hsync=1, vsync=1, red=green=blue=0, lit=0.
REQ-025 Reset values: x=0, y=0, frame counter=0, hs_d=vs_d=1, FSM=DARK, LFSR=8'hA5.
REQ-026 Reset asserted mid-frame SHALL take effect immediately (asynchronous); after release, first vs_rise begins frame counting at 0.
REQ-027 Deasserted reset SHALL not itself produce an hs_rise or vs_rise.

Verification
REQ-028 Pass-through: enable=0, drive 1040x666 timing with arbitrary rgb -> outputs equal inputs delayed exactly 1 clk, lit=0 throughout.
REQ-029 Blink timing: enable=1, BLINK_FRAMES=3 -> lit rises after 3rd vs_rise, falls after 6th, rises after 9th; LFSR = 0xA5 shifted once, then twice at those points.
REQ-030 Ornament mapping: LIT, green input at x=6..9, y=6..9 with lfsr[2:0]=101 -> output {r,g,b}=101; at x=5 or y=10 -> output 010 unchanged.
REQ-031 Substitution: choose x,y so c=010 -> output 111; sky pixel (001) at same x,y -> 001.
REQ-032 Boundary: hs_rise and vs_rise in same cycle -> y=0; hold hsync_in high 3000 clks -> x saturates 2047, no wrap.
REQ-033 Reset mid-LIT: assert reset at frame 4 -> outputs 0/syncs 1 same cycle, lit=0, LFSR=0xA5 after release.

Source files
------------

// File: rtl/xmas_twinkle.sv
// rtl/xmas_twinkle.sv - twinkling ornament overlay on the tree renderer pixel stream
// One-clock pipeline: syncs and colour are re-registered together so they stay aligned.
module xmas_twinkle #(
    parameter int unsigned BLINK_FRAMES = 30
) (
    input  logic clk,
    input  logic reset,
    input  logic enable,
    input  logic hsync_in,
    input  logic vsync_in,
    input  logic red_in,
    input  logic green_in,
    input  logic blue_in,
    output logic hsync,
    output logic vsync,
    output logic red,
    output logic green,
    output logic blue,
    output logic lit
);

    typedef enum logic {DARK = 1'b0, LIT = 1'b1} state_t;

    localparam logic [7:0]  FRAME_LAST = 8'(BLINK_FRAMES - 1);
    localparam logic [10:0] X_MAX      = 11'h7FF;
    localparam logic [9:0]  Y_MAX      = 10'h3FF;
    localparam logic [7:0]  LFSR_SEED  = 8'hA5;

    state_t      state_q, state_d;
    logic        hs_d_q, hs_d_d;
    logic        vs_d_q, vs_d_d;
    logic [10:0] x_q, x_d;
    logic [9:0]  y_q, y_d;
    logic [7:0]  frame_q, frame_d;
    logic [7:0]  lfsr_q, lfsr_d;
    logic        hsync_q, hsync_d;
    logic        vsync_q, vsync_d;
    logic [2:0]  rgb_q, rgb_d;
    logic        lit_q, lit_d;

    logic        hs_rise;
    logic        vs_rise;
    logic        lfsr_fb;
    logic        orn_hit;
    logic [2:0]  rgb_in_v;
    logic [2:0]  orn_c;

    always_comb begin
        hs_rise  = hsync_in & ~hs_d_q;
        vs_rise  = vsync_in & ~vs_d_q;
        hs_d_d   = hsync_in;
        vs_d_d   = vsync_in;
        hsync_d  = hsync_in;
        vsync_d  = vsync_in;
        rgb_in_v = {red_in, green_in, blue_in};

        x_d = hs_rise ? 11'd0 : ((x_q == X_MAX) ? x_q : x_q + 11'd1);

        // A frame start wins over a line start landing on the same clock.
        if (vs_rise) begin
            y_d = 10'd0;
        end else if (hs_rise && (y_q != Y_MAX)) begin
            y_d = y_q + 10'd1;
        end else begin
            y_d = y_q;
        end

        lfsr_fb = lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3];
        frame_d = frame_q;
        state_d = state_q;
        lfsr_d  = lfsr_q;
        if (!enable) begin
            frame_d = 8'd0;
            state_d = DARK;
        end else if (vs_rise) begin
            if (frame_q == FRAME_LAST) begin
                frame_d = 8'd0;
                if (state_q == DARK) begin
                    state_d = LIT;
                    lfsr_d  = {lfsr_q[6:0], lfsr_fb};
                end else begin
                    state_d = DARK;
                end
            end else begin
                frame_d = frame_q + 8'd1;
            end
        end
        lit_d = (state_d == LIT);

        // Pixel decision uses the counters as they stood before this clock.
        orn_hit = (x_q[3:0] >= 4'd6) && (x_q[3:0] <= 4'd9)
               && (y_q[3:0] >= 4'd6) && (y_q[3:0] <= 4'd9)
               && (rgb_in_v == 3'b010);
        orn_c = lfsr_q[2:0] ^ x_q[6:4] ^ y_q[6:4];
        if ((orn_c == 3'b000) || (orn_c == 3'b010)) begin
            orn_c = 3'b111;
        end
        rgb_d = ((state_q == LIT) && orn_hit) ? orn_c : rgb_in_v;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= DARK;
            hs_d_q  <= 1'b1;
            vs_d_q  <= 1'b1;
            x_q     <= 11'd0;
            y_q     <= 10'd0;
            frame_q <= 8'd0;
            lfsr_q  <= LFSR_SEED;
            hsync_q <= 1'b1;
            vsync_q <= 1'b1;
            rgb_q   <= 3'b000;
            lit_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            hs_d_q  <= hs_d_d;
            vs_d_q  <= vs_d_d;
            x_q     <= x_d;
            y_q     <= y_d;
            frame_q <= frame_d;
            lfsr_q  <= lfsr_d;
            hsync_q <= hsync_d;
            vsync_q <= vsync_d;
            rgb_q   <= rgb_d;
            lit_q   <= lit_d;
        end
    end

    assign hsync = hsync_q;
    assign vsync = vsync_q;
    assign red   = rgb_q[2];
    assign green = rgb_q[1];
    assign blue  = rgb_q[0];
    assign lit   = lit_q;

endmodule

// File: tb/tb_xmas_twinkle.sv
// tb/tb_xmas_twinkle.sv - randomized video stimulus checked against a behavioural twinkle model
module tb_xmas_twinkle;

    localparam int BF = 3;

    logic clk = 1'b0;
    logic reset, enable, hsync_in, vsync_in, red_in, green_in, blue_in;
    logic hsync, vsync, red, green, blue, lit;

    always #5 clk = ~clk;

    xmas_twinkle #(.BLINK_FRAMES(BF)) dut (
        .clk      (clk),
        .reset    (reset),
        .enable   (enable),
        .hsync_in (hsync_in),
        .vsync_in (vsync_in),
        .red_in   (red_in),
        .green_in (green_in),
        .blue_in  (blue_in),
        .hsync    (hsync),
        .vsync    (vsync),
        .red      (red),
        .green    (green),
        .blue     (blue),
        .lit      (lit)
    );

    int tests = 0;
    int fails = 0;

    // Model state: position counters, vs_rises counted since enable/reset, LFSR value.
    int         mx, my, mcnt;
    logic [7:0] mlfsr;
    logic       mhd, mvd, m_hr, m_vr, m_lit_now, m_orn;
    logic [2:0] m_c, m_in;
    logic       e_hs, e_vs, e_lit;
    logic [2:0] e_rgb;

    function automatic logic [7:0] lfsr_next(input logic [7:0] v);
        return {v[6:0], ^(v & 8'hB8)};
    endfunction

    initial forever begin
        @(posedge clk or posedge reset);
        if (reset) begin
            mx = 0; my = 0; mcnt = 0; mlfsr = 8'hA5; mhd = 1'b1; mvd = 1'b1;
            e_hs = 1'b1; e_vs = 1'b1; e_rgb = 3'b000; e_lit = 1'b0;
        end else begin
            m_in      = {red_in, green_in, blue_in};
            m_hr      = hsync_in && !mhd;
            m_vr      = vsync_in && !mvd;
            m_lit_now = ((mcnt / BF) % 2) == 1;
            m_orn     = (mx % 16 >= 6) && (mx % 16 <= 9) && (my % 16 >= 6) && (my % 16 <= 9)
                     && (m_in == 3'b010);
            m_c = mlfsr[2:0] ^ 3'((mx / 16) % 8) ^ 3'((my / 16) % 8);
            if (m_c == 3'b000 || m_c == 3'b010) m_c = 3'b111;
            e_rgb = (m_lit_now && m_orn) ? m_c : m_in;
            e_hs  = hsync_in;
            e_vs  = vsync_in;
            mx = m_hr ? 0 : ((mx < 2047) ? mx + 1 : 2047);
            if (m_vr) my = 0;
            else if (m_hr && my < 1023) my = my + 1;
            if (!enable) begin
                mcnt = 0;
            end else if (m_vr) begin
                mcnt = mcnt + 1;
                if ((mcnt % BF) == 0 && ((mcnt / BF) % 2) == 1) mlfsr = lfsr_next(mlfsr);
            end
            e_lit = ((mcnt / BF) % 2) == 1;
            mhd = hsync_in;
            mvd = vsync_in;
        end
    end

    initial forever begin
        @(negedge clk);
        tests++;
        if ({hsync, vsync, red, green, blue, lit} !== {e_hs, e_vs, e_rgb, e_lit}) begin
            fails++;
            $display("FAIL cycle_compare t=%0t got hs=%b vs=%b rgb=%b%b%b lit=%b exp hs=%b vs=%b rgb=%b lit=%b",
                     $time, hsync, vsync, red, green, blue, lit, e_hs, e_vs, e_rgb, e_lit);
        end
    end

    task automatic chk(input string name, input logic [5:0] got, input logic [5:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%b exp=%b", name, got, exp);
        end
    endtask

    task automatic pix(input logic [2:0] c, input logic hs, input logic vs);
        {red_in, green_in, blue_in} = c;
        hsync_in = hs;
        vsync_in = vs;
        @(negedge clk);
    endtask

    function automatic logic [2:0] rand_colour(input int line, input int col);
        if (line < 3 || col < 8) return 3'b000;
        return ($urandom_range(0, 1) == 1) ? 3'b010 : 3'($urandom_range(0, 7));
    endfunction

    task automatic random_frame(input int h, input int v);
        for (int line = 0; line < v; line++)
            for (int col = 0; col < h; col++)
                pix(rand_colour(line, col), col >= 4, line >= 2);
    endtask

    task automatic random_lines(input int n, input int h);
        for (int line = 0; line < n; line++)
            for (int col = 0; col < h; col++)
                pix(rand_colour(line + 3, col), col >= 4, 1'b1);
    endtask

    task automatic hs_pulse();
        pix(3'b000, 1'b0, 1'b1);
        pix(3'b000, 1'b1, 1'b1);
    endtask

    function automatic logic [2:0] row_exp(input bit mode_b, input int j);
        if (j == 5 || j == 10) return 3'b010;
        if (mode_b) return 3'b101;
        return (j == 7) ? 3'b001 : 3'b111;
    endfunction

    function automatic logic lit_after(input int k);
        return (k == 3 || k == 4 || k == 5 || k == 9 || k == 10);
    endfunction

    // Frame whose vs_rise coincides with an hs_rise, then a hand-placed ornament row.
    task automatic dir_frame(input bit mode_b);
        logic [2:0] c;
        pix(3'b000, 1'b0, 1'b0);
        pix(3'b000, 1'b1, 1'b1);
        repeat (5) hs_pulse();
        for (int j = 0; j < 8; j++) begin
            pix(3'b010, 1'b1, 1'b1);
            if (j == 6) chk("row_y5_untouched", {3'b000, red, green, blue}, 6'b000010);
        end
        hs_pulse();
        for (int j = 0; j < 12; j++) begin
            c = (!mode_b && j == 7) ? 3'b001 : 3'b010;
            pix(c, 1'b1, 1'b1);
            if (j >= 5 && j <= 10)
                chk($sformatf("row_y6_x%0d_%s", j, mode_b ? "b" : "a"),
                    {3'b000, red, green, blue}, {3'b000, row_exp(mode_b, j)});
        end
        if (mode_b) begin
            repeat (3000) pix(3'b010, 1'b1, 1'b1);
            chk("x_saturated", {3'b000, red, green, blue}, 6'b000010);
            repeat (4) hs_pulse();
            for (int j = 0; j < 8; j++) begin
                pix(3'b010, 1'b1, 1'b1);
                if (j == 6) chk("row_y10_untouched", {3'b000, red, green, blue}, 6'b000010);
            end
        end
        random_lines(3, 40);
    endtask

    initial begin
        reset = 1'b1; enable = 1'b0; hsync_in = 1'b1; vsync_in = 1'b1;
        {red_in, green_in, blue_in} = 3'b000;
        repeat (3) @(negedge clk);
        chk("reset_state", {hsync, vsync, red, green, blue, lit}, 6'b110000);
        reset = 1'b0;

        random_frame(1040, 12);
        chk("passthru_lit", {5'd0, lit}, 6'd0);

        enable = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            if (k == 3) dir_frame(1'b0);
            else if (k == 9) dir_frame(1'b1);
            else random_frame(40, 20);
            chk($sformatf("lit_after_vs%0d", k), {5'd0, lit}, {5'd0, lit_after(k)});
        end

        enable = 1'b0;
        random_frame(40, 20);
        enable = 1'b1;
        for (int k = 1; k <= 4; k++) random_frame(40, 20);
        chk("lit_frame4", {5'd0, lit}, 6'd1);
        random_lines(5, 40);
        @(posedge clk);
        #2 reset = 1'b1;
        #1 chk("reset_async", {hsync, vsync, red, green, blue, lit}, 6'b110000);
        @(negedge clk);
        hsync_in = 1'b1; vsync_in = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        random_frame(40, 20);
        random_frame(40, 20);
        chk("lit_dark_after_reset", {5'd0, lit}, 6'd0);
        dir_frame(1'b0);
        chk("lit_relit_after_reset", {5'd0, lit}, 6'd1);

        for (int k = 0; k < 6; k++) begin
            enable = ($urandom_range(0, 3) != 0);
            random_frame(40, 20);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
